mm_burst: RTL

Parametrised main-memory model with a request/ready handshake, programmable access latency and fixed-length block bursts, serving cache line fills and write-backs. Sits behind the cache controller in place of the single-word main memory. Each accepted request moves one aligned block of BURST_LEN words after LATENCY wait cycles. Storage contents are not cleared by reset.

---
 rtl/mm_burst_pkg.sv | 15 +
 rtl/mm_burst_if.sv | 35 +++
 rtl/mm_burst_array.sv | 43 ++++
 rtl/mm_burst.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mm_burst_pkg.sv
// Shared types and helpers for the mm_burst burst-memory model.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } mm_state_e;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_burst_if.sv
// Request / beat bus between the cache controller (master) and mm_burst (slave).
// The err signal exists only when MM_BOUNDS_CHECK_EN is defined.
interface mm_burst_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              done;
`ifdef MM_BOUNDS_CHECK_EN
  logic              err;
`endif

  modport master (
    output req_valid, req_we, req_addr, wr_data,
    input  req_ready, wr_ready, rd_valid, rd_data, done
`ifdef MM_BOUNDS_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  req_valid, req_we, req_addr, wr_data,
    output req_ready, wr_ready, rd_valid, rd_data, done
`ifdef MM_BOUNDS_CHECK_EN
    , output err
`endif
  );
endinterface

// File: rtl/mm_burst_array.sv
// Storage for mm_burst: DEPTH x DATA_W, synchronous write, registered read.
// Addresses at or beyond DEPTH drop writes and read back as zero.
module mm_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 20,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              w_in_range;
  logic              r_in_range;

  assign w_in_range = (32'(waddr_i) < 32'(DEPTH));
  assign r_in_range = (32'(raddr_i) < 32'(DEPTH));

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i && w_in_range) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= r_in_range ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mm_burst.sv
// Main-memory model: one aligned BURST_LEN-word burst per request after LATENCY wait cycles.
// Define MM_BOUNDS_CHECK_EN to reject out-of-range bursts with an err pulse.
module mm_burst
  import mm_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 20,
  parameter int ADDR_W    = 5,
  parameter int BURST_LEN = 4,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       rst,
  mm_burst_if.slave  bus
);

  localparam int BW = cnt_w(BURST_LEN);
  localparam int LW = cnt_w(LATENCY);
  localparam logic [BW-1:0]     BEAT_LAST  = BW'(BURST_LEN - 1);
  localparam logic [LW-1:0]     LAT_INIT   = (LATENCY > 0) ? LW'(LATENCY - 1) : '0;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN - 1);

  mm_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              oob_q, oob_d;

  logic [ADDR_W-1:0] aligned;
  logic              oob_req;
  logic              rd_issue;
  logic [ADDR_W-1:0] rd_addr;
  logic              in_burst;

  assign aligned = bus.req_addr & ALIGN_MASK;

`ifdef MM_BOUNDS_CHECK_EN
  assign oob_req = (({1'b0, aligned} + (ADDR_W+1)'(BURST_LEN - 1)) >= (ADDR_W+1)'(DEPTH));
`else
  assign oob_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      oob_q   <= oob_d;
    end
  end

  // The array read is issued in the cycle before each read beat.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    base_d   = base_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    oob_d    = oob_q;
    rd_issue = 1'b0;
    rd_addr  = base_q + ADDR_W'(beat_q) + ADDR_W'(1);
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          base_d = aligned;
          beat_d = '0;
          lat_d  = LAT_INIT;
          if (oob_req) begin
            oob_d   = 1'b1;
            state_d = WAIT;
          end else if (LATENCY == 0) begin
            state_d  = BURST;
            rd_issue = ~bus.req_we;
            rd_addr  = aligned;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (oob_q) begin
          oob_d   = 1'b0;
          state_d = IDLE;
        end else if (lat_q == '0) begin
          state_d  = BURST;
          rd_issue = ~we_q;
          rd_addr  = base_q;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      BURST: begin
        if (beat_q == BEAT_LAST) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d   = beat_q + BW'(1);
          rd_issue = ~we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_burst      = (state_q == BURST) && !rst;
  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.rd_valid  = in_burst && !we_q;
  assign bus.wr_ready  = in_burst && we_q;
  assign bus.done      = in_burst && (beat_q == BEAT_LAST);
`ifdef MM_BOUNDS_CHECK_EN
  assign bus.err       = (state_q == WAIT) && oob_q && !rst;
`endif

  mm_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.wr_ready),
    .waddr_i (base_q + ADDR_W'(beat_q)),
    .wdata_i (bus.wr_data),
    .re_i    (rd_issue && !rst),
    .raddr_i (rd_addr),
    .rdata_o (bus.rd_data)
  );

endmodule
